pattern_presenter: RTL and testbench
====================================

# pattern_presenter

Drives the "show" phase of the memory tester game. It plays a captured sequence of 4-bit symbols on the LEDs, one symbol at a time, with a blank gap between symbols. It is the initiator side of the reconfigurable countdown timer handshake: it loads the timer's `reconfig` value, fires `time_in`, and waits for the `time_out` pulse before advancing. It sits between the game controller, which supplies `start` and `pattern`, and the timer instance. When the sequence ends it hands control back with `done`.

## Interface
- `SEQ_LEN`, default 4: number of symbols per sequence, legal range 1..8.
- `SHOW_TICKS`, default 4'd9: `reconfig` value for each symbol-visible phase.
- `GAP_TICKS`, default 4'd3: `reconfig` value for each blank phase.

Ports (name, direction, width, meaning):
- `clock`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a sequence. Sampled only in IDLE.
- `abort`, in, 1: cancel the sequence in progress.
- `pattern`, in, 4*SEQ_LEN: symbol k is `pattern[4k+3:4k]`. Captured on the accepted `start`.
- `time_out`, in, 1: one-cycle completion pulse from the timer.
- `time_in`, out, 1: one-cycle timer start pulse.
- `reconfig`, out, 4: timer load value. Valid whenever `time_in` is high.
- `leds`, out, 4: the symbol currently shown, or 0.
- `step`, out, 3: index of the current symbol.
- `busy`, out, 1: high from the accepted `start` until the sequence completes or the drain completes.
- `done`, out, 1: one-cycle pulse on normal completion.

## Operation
- States: IDLE, SHOW_REQ, SHOW_WAIT, GAP_REQ, GAP_WAIT, FINISH, DRAIN.
- IDLE, with `start` = 1:
  - capture `pattern`;
  - set `step` = 0;
  - go to SHOW_REQ.
- SHOW_REQ (one cycle):
  - `time_in` = 1, `reconfig` = SHOW_TICKS;
  - `leds` = symbol[`step`];
  - set `tmr_busy`;
  - go to SHOW_WAIT.
- SHOW_WAIT: hold `leds`. On `time_out`, clear `tmr_busy` and go to GAP_REQ.
- GAP_REQ (one cycle):
  - `time_in` = 1, `reconfig` = GAP_TICKS;
  - `leds` = 0;
  - set `tmr_busy`;
  - go to GAP_WAIT.
- GAP_WAIT: on `time_out`, clear `tmr_busy`.
  - If `step` = SEQ_LEN-1, go to FINISH.
  - Otherwise increment `step` and go to SHOW_REQ.
- FINISH (one cycle): `done` = 1, then go to IDLE.
- Abort: `abort` = 1 in any state other than IDLE or DRAIN forces `leds` = 0.
  - If `tmr_busy` is set (a timer run is outstanding), go to DRAIN.
  - Otherwise go to IDLE.
- DRAIN: `busy` stays 1 and `leds` = 0. On `time_out`, clear `tmr_busy` and go to IDLE.
  - Purpose: a new `start` can never send `time_in` to a timer that is still counting. The timer ignores `time_in` while it is counting.
- `time_out` arriving in IDLE, SHOW_REQ, GAP_REQ or FINISH is ignored.
- `start` arriving outside IDLE is ignored. `pattern` changes after capture have no effect.
- Simultaneous events:
  - `abort` and `time_out` in a WAIT state: `abort` wins. `tmr_busy` clears and the block goes to IDLE, not DRAIN.
  - `abort` in IDLE has no effect.
  - `abort` and `start` in IDLE: the start is accepted.
- `reconfig` holds its last driven value between requests. Only the value during the `time_in` cycle matters.

## Timing
- Reset values: `time_in` = 0, `reconfig` = 0, `leds` = 0, `step` = 0, `busy` = 0, `done` = 0, `tmr_busy` = 0, state IDLE.
- `rst` mid-sequence returns to IDLE immediately. The timer must be reset in the same cycle, since DRAIN is not used.
- All outputs are registered. `start` sampled at edge N gives `time_in` = 1 and `leds` = symbol 0 in cycle N+1.
- With the paired timer, a `time_in` at cycle c with `reconfig` = R produces `time_out` at cycle c+R+2.
- Each phase lasts R+3 cycles from one `time_in` to the next.
  - With the defaults: show = 12 cycles, gap = 6 cycles, 18 cycles per step.
- `done` is high in the cycle after the final gap `time_out` is sampled. `busy` falls in the following cycle.
- `step` changes in the cycle `leds` loads the next symbol.

## Test plan
- Defaults, `pattern` = 16'h8421, `start` pulsed at cycle 0:
  - `leds` = 1, 2, 4, 8 starting at cycles 1, 19, 37, 55, each held 12 cycles;
  - `leds` = 0 for the 6 cycles between symbols;
  - `done` at cycle 73, `busy` low from cycle 74.
- Check every `time_in` pulse: exactly 1 cycle wide, `reconfig` = 9 on show pulses and 3 on gap pulses, 8 pulses total.
- `abort` at cycle 5 (timer running):
  - `leds` = 0 at cycle 6;
  - `busy` stays 1 until the `time_out` at cycle 12, and is 0 at cycle 13;
  - a `start` at cycle 6 is ignored, a `start` at cycle 13 is accepted.
- `start` re-pulsed at cycle 20 and `pattern` changed mid-run: no effect on the sequence. A stray `time_out` injected in IDLE produces no `time_in`.
- SEQ_LEN = 1, SHOW_TICKS = 0, GAP_TICKS = 0: show phase 3 cycles, gap phase 3 cycles, `done` at cycle 7.
- `rst` asserted at cycle 30: every output matches its reset value at cycle 31.

Source files
------------

// File: rtl/pattern_presenter.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_presenter
//  Purpose  : Plays a captured sequence of 4-bit symbols on the LEDs, with a
//             blank gap between symbols. Each phase is timed by an external
//             reconfigurable countdown timer: this block loads the timer's
//             reconfig value, pulses time_in and waits for time_out.
//             Handing back to the game controller is signalled by done.
//  Revision : 1.0  initial release
// ============================================================================
module pattern_presenter #(
  parameter int         SEQ_LEN    = 4,
  parameter logic [3:0] SHOW_TICKS = 4'd9,
  parameter logic [3:0] GAP_TICKS  = 4'd3
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [4*SEQ_LEN-1:0]   pattern,
  input  logic                   time_out,
  output logic                   time_in,
  output logic [3:0]             reconfig,
  output logic [3:0]             leds,
  output logic [2:0]             step,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SHOW_REQ  = 3'd1,
    S_SHOW_WAIT = 3'd2,
    S_GAP_REQ   = 3'd3,
    S_GAP_WAIT  = 3'd4,
    S_FINISH    = 3'd5,
    S_DRAIN     = 3'd6
  } state_t;

  localparam logic [2:0] c_last_step = 3'(SEQ_LEN - 1);

  state_t                 state_q,    state_d;
  logic [2:0]             step_q,     step_d;
  logic [4*SEQ_LEN-1:0]   pattern_q,  pattern_d;
  logic                   tmr_busy_q, tmr_busy_d;
  logic                   time_in_q,  time_in_d;
  logic [3:0]             reconfig_q, reconfig_d;
  logic [3:0]             leds_q,     leds_d;
  logic                   busy_q,     busy_d;
  logic                   done_q,     done_d;

  // While idle the first symbol must come straight from the input bus,
  // because the capture register only loads on the same edge.
  logic [4*SEQ_LEN-1:0]   w_sym_src;
  logic [3:0]             w_sym [8];
  logic                   w_abort_hit;

  assign w_sym_src   = (state_q == S_IDLE) ? pattern : pattern_q;
  assign w_abort_hit = abort && (state_q != S_IDLE) && (state_q != S_DRAIN);

  // Symbol table padded to 8 entries so a 3-bit step always indexes in range.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_sym
      if (gi < SEQ_LEN) begin : g_used
        assign w_sym[gi] = w_sym_src[4*gi +: 4];
      end else begin : g_unused
        assign w_sym[gi] = 4'd0;
      end
    end
  endgenerate

  // Next-state logic plus next values of every registered output.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    pattern_d  = pattern_q;
    tmr_busy_d = tmr_busy_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pattern_d = pattern;
          step_d    = 3'd0;
          state_d   = S_SHOW_REQ;
        end
      end
      S_SHOW_REQ: state_d = S_SHOW_WAIT;
      S_SHOW_WAIT: begin
        if (time_out) begin
          tmr_busy_d = 1'b0;
          state_d    = S_GAP_REQ;
        end
      end
      S_GAP_REQ: state_d = S_GAP_WAIT;
      S_GAP_WAIT: begin
        if (time_out) begin
          tmr_busy_d = 1'b0;
          if (step_q == c_last_step) begin
            state_d = S_FINISH;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = S_SHOW_REQ;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_DRAIN: begin
        if (time_out) begin
          tmr_busy_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides the normal flow. A timer run still outstanding after
    // this cycle (tmr_busy_d) must be drained before a new start is allowed;
    // a time_out arriving together with abort has already cleared it.
    if (w_abort_hit) begin
      step_d  = step_q;
      state_d = tmr_busy_d ? S_DRAIN : S_IDLE;
    end

    // A request cycle launches the timer, so it counts as outstanding from
    // the request cycle itself (an abort during the request must drain).
    if ((state_d == S_SHOW_REQ) || (state_d == S_GAP_REQ)) begin
      tmr_busy_d = 1'b1;
    end

    time_in_d  = (state_d == S_SHOW_REQ) || (state_d == S_GAP_REQ);
    reconfig_d = reconfig_q;
    if (state_d == S_SHOW_REQ) begin
      reconfig_d = SHOW_TICKS;
    end else if (state_d == S_GAP_REQ) begin
      reconfig_d = GAP_TICKS;
    end

    case (state_d)
      S_SHOW_REQ:  leds_d = w_sym[step_d];
      S_SHOW_WAIT: leds_d = leds_q;
      default:     leds_d = 4'd0;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= S_IDLE;
      step_q     <= 3'd0;
      pattern_q  <= '0;
      tmr_busy_q <= 1'b0;
      time_in_q  <= 1'b0;
      reconfig_q <= 4'd0;
      leds_q     <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      pattern_q  <= pattern_d;
      tmr_busy_q <= tmr_busy_d;
      time_in_q  <= time_in_d;
      reconfig_q <= reconfig_d;
      leds_q     <= leds_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign time_in  = time_in_q;
  assign reconfig = reconfig_q;
  assign leds     = leds_q;
  assign step     = step_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_presenter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pattern_presenter
//  Purpose  : Directed bench for pattern_presenter with a behavioural model of
//             the paired countdown timer (time_in at c, reconfig R gives
//             time_out at c+R+2; time_in ignored while counting).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pattern_presenter;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;

  // Instance A: default parameters
  logic        start_a = 1'b0, abort_a = 1'b0, inj_a = 1'b0;
  logic [15:0] pattern_a = 16'h0;
  logic        time_out_a, time_in_a, busy_a, done_a;
  logic [3:0]  reconfig_a, leds_a;
  logic [2:0]  step_a;

  // Instance B: one symbol, zero-length phases
  logic        start_b = 1'b0, abort_b = 1'b0;
  logic [3:0]  pattern_b = 4'h0;
  logic        time_out_b, time_in_b, busy_b, done_b;
  logic [3:0]  reconfig_b, leds_b;
  logic [2:0]  step_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  pattern_presenter u_dut_a (
    .clock(clock), .rst(rst), .start(start_a), .abort(abort_a),
    .pattern(pattern_a), .time_out(time_out_a), .time_in(time_in_a),
    .reconfig(reconfig_a), .leds(leds_a), .step(step_a),
    .busy(busy_a), .done(done_a)
  );

  pattern_presenter #(.SEQ_LEN(1), .SHOW_TICKS(4'd0), .GAP_TICKS(4'd0)) u_dut_b (
    .clock(clock), .rst(rst), .start(start_b), .abort(abort_b),
    .pattern(pattern_b), .time_out(time_out_b), .time_in(time_in_b),
    .reconfig(reconfig_b), .leds(leds_b), .step(step_b),
    .busy(busy_b), .done(done_b)
  );

  // Timer models
  logic [3:0] cnt_a, cnt_b;
  logic       run_a, run_b, tout_a, tout_b;

  always @(posedge clock) begin
    if (rst) begin
      cnt_a <= 4'd0; run_a <= 1'b0; tout_a <= 1'b0;
    end else begin
      tout_a <= 1'b0;
      if (run_a) begin
        if (cnt_a == 4'd0) begin tout_a <= 1'b1; run_a <= 1'b0; end
        else cnt_a <= cnt_a - 4'd1;
      end
      if (time_in_a && !run_a) begin cnt_a <= reconfig_a; run_a <= 1'b1; end
    end
  end

  always @(posedge clock) begin
    if (rst) begin
      cnt_b <= 4'd0; run_b <= 1'b0; tout_b <= 1'b0;
    end else begin
      tout_b <= 1'b0;
      if (run_b) begin
        if (cnt_b == 4'd0) begin tout_b <= 1'b1; run_b <= 1'b0; end
        else cnt_b <= cnt_b - 4'd1;
      end
      if (time_in_b && !run_b) begin cnt_b <= reconfig_b; run_b <= 1'b1; end
    end
  end

  assign time_out_a = tout_a | inj_a;
  assign time_out_b = tout_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  initial begin
    int pulses;
    int off, k;
    logic [3:0] exp_leds;
    logic       exp_ti;

    repeat (3) @(negedge clock);
    // Reset state, sampled while reset still held
    check("rst_time_in", {31'd0, time_in_a}, 32'd0);
    check("rst_busy",    {31'd0, busy_a},    32'd0);
    check("rst_leds",    {28'd0, leds_a},    32'd0);
    rst = 1'b0;
    @(negedge clock);

    // ---- Scenario 1: full default sequence, ignored re-start, pattern
    //      change mid-run, stray time_out in idle
    pulses = 0;
    for (int t = 0; t <= 78; t++) begin
      if (t >= 1 && t <= 72) begin
        off      = (t - 1) % 18;
        k        = (t - 1) / 18;
        exp_leds = (off < 12) ? 4'(1 << k) : 4'd0;
        exp_ti   = (off == 0) || (off == 12);
        check($sformatf("s1_leds_c%0d", t),    {28'd0, leds_a},    {28'd0, exp_leds});
        check($sformatf("s1_time_in_c%0d", t), {31'd0, time_in_a}, {31'd0, exp_ti});
        check($sformatf("s1_step_c%0d", t),    {29'd0, step_a},    k);
        if (exp_ti)
          check($sformatf("s1_reconfig_c%0d", t), {28'd0, reconfig_a},
                (off == 0) ? 32'd9 : 32'd3);
      end else begin
        check($sformatf("s1_leds_c%0d", t),    {28'd0, leds_a},    32'd0);
        check($sformatf("s1_time_in_c%0d", t), {31'd0, time_in_a}, 32'd0);
      end
      check($sformatf("s1_done_c%0d", t), {31'd0, done_a}, {31'd0, (t == 73)});
      check($sformatf("s1_busy_c%0d", t), {31'd0, busy_a}, {31'd0, (t >= 1 && t <= 73)});
      if (time_in_a) pulses++;
      start_a   = (t == 0) || (t == 20);
      pattern_a = (t >= 25) ? 16'hFFFF : 16'h8421;
      inj_a     = (t == 76);
      @(negedge clock);
    end
    check("s1_pulse_count", pulses, 32'd8);

    // ---- Scenario 2: abort while timer running, drain, restart, reset
    for (int t = 0; t <= 31; t++) begin
      if (t == 6) check("s2_leds_after_abort", {28'd0, leds_a}, 32'd0);
      if (t >= 6 && t <= 12)
        check($sformatf("s2_drain_busy_c%0d", t), {31'd0, busy_a}, 32'd1);
      if (t == 7) check("s2_start_in_drain_ignored", {31'd0, time_in_a}, 32'd0);
      if (t == 13) check("s2_busy_after_drain", {31'd0, busy_a}, 32'd0);
      if (t == 14) begin
        check("s2_restart_time_in",  {31'd0, time_in_a},  32'd1);
        check("s2_restart_leds",     {28'd0, leds_a},     32'd1);
        check("s2_restart_reconfig", {28'd0, reconfig_a}, 32'd9);
      end
      if (t == 31) begin
        check("s2_rst_time_in",  {31'd0, time_in_a},  32'd0);
        check("s2_rst_reconfig", {28'd0, reconfig_a}, 32'd0);
        check("s2_rst_leds",     {28'd0, leds_a},     32'd0);
        check("s2_rst_step",     {29'd0, step_a},     32'd0);
        check("s2_rst_busy",     {31'd0, busy_a},     32'd0);
        check("s2_rst_done",     {31'd0, done_a},     32'd0);
      end
      start_a   = (t == 0) || (t == 6) || (t == 13);
      abort_a   = (t == 5);
      pattern_a = 16'h8421;
      rst       = (t == 30);
      @(negedge clock);
    end
    rst     = 1'b0;
    start_a = 1'b0;
    abort_a = 1'b0;
    @(negedge clock);

    // ---- Scenario 3: abort coincident with time_out goes straight to idle;
    //      abort together with start in idle accepts the start
    for (int t = 0; t <= 15; t++) begin
      if (t == 13) begin
        check("s3_busy_abort_tout", {31'd0, busy_a}, 32'd0);
        check("s3_leds_abort_tout", {28'd0, leds_a}, 32'd0);
      end
      if (t == 14) check("s3_still_idle", {31'd0, busy_a}, 32'd0);
      if (t == 15) begin
        check("s3_abort_start_time_in", {31'd0, time_in_a}, 32'd1);
        check("s3_abort_start_busy",    {31'd0, busy_a},    32'd1);
        check("s3_abort_start_leds",    {28'd0, leds_a},    32'd1);
      end
      start_a = (t == 0) || (t == 14);
      abort_a = (t == 12) || (t == 14);
      @(negedge clock);
    end
    start_a = 1'b0;
    abort_a = 1'b0;

    // ---- Scenario 4: single symbol, zero-tick phases (instance B)
    for (int t = 0; t <= 9; t++) begin
      check($sformatf("s4_time_in_c%0d", t), {31'd0, time_in_b}, {31'd0, (t == 1 || t == 4)});
      check($sformatf("s4_leds_c%0d", t),    {28'd0, leds_b},
            (t >= 1 && t <= 3) ? 32'hA : 32'd0);
      check($sformatf("s4_done_c%0d", t),    {31'd0, done_b},    {31'd0, (t == 7)});
      check($sformatf("s4_busy_c%0d", t),    {31'd0, busy_b},    {31'd0, (t >= 1 && t <= 7)});
      start_b   = (t == 0);
      pattern_b = 4'hA;
      @(negedge clock);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
